// File: rtl/asym_ram_stream_reader.sv
// asym_ram_stream_reader
// Read-side sequencer for the asymmetric line buffer. It accepts one command
// at a time (base address + beat count), walks the narrow RAM read port with
// an address that wraps modulo the buffer depth, and turns the RAM's
// 1-cycle-latency data into an AXI-Stream through a 2-entry skid FIFO.
//
// Credit scheme: a read is only issued when the FIFO has room for the data.
// Room means (fifo_count + inflight) < 2, or the sum is exactly 2 and a pop
// happens in the same cycle. This lets the stream run at one beat per cycle
// with tready held high, and it guarantees the FIFO can never overflow.
module asym_ram_stream_reader #(
  parameter int WIDTHB     = 4,
  parameter int ADDRWIDTHB = 10,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDRWIDTHB-1:0] cmd_base,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  ram_en,
  output logic [ADDRWIDTHB-1:0] ram_addr,
  input  logic [WIDTHB-1:0]     ram_data,
  output logic [WIDTHB-1:0]     m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Control / handshake registers
  logic                  r_cmd_ready;
  logic                  r_busy;

  // Read sequencing
  logic [ADDRWIDTHB-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic                  r_inflight;
  logic                  r_inflight_last;

  // 2-entry output FIFO
  logic [WIDTHB-1:0]     r_fifo_data [0:1];
  logic                  r_fifo_last [0:1];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_fifo_count;

  // Combinational helpers
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_push;
  logic [1:0]            w_occupancy;
  logic                  w_issue;
  logic                  w_last_issue;
  logic                  w_len_zero;
  logic                  w_fifo_empty;

  // Handshake qualifiers and FIFO occupancy seen by the credit check
  always_comb begin
    w_accept     = cmd_valid & r_cmd_ready & (r_state == S_IDLE);
    w_len_zero   = (cmd_len == LEN_WIDTH'(0));
    w_fifo_empty = (r_fifo_count == 2'd0);
    w_pop        = (~w_fifo_empty) & m_axis_tready;
    w_push       = r_inflight;
    w_occupancy  = r_fifo_count + {1'b0, r_inflight};
  end

  // Read issue decision: only in RUN and only when the FIFO will have room
  always_comb begin
    w_issue = 1'b0;
    if (r_state == S_RUN) begin
      if (w_occupancy < 2'd2) begin
        w_issue = 1'b1;
      end else if ((w_occupancy == 2'd2) && w_pop) begin
        w_issue = 1'b1;
      end else begin
        w_issue = 1'b0;
      end
    end else begin
      w_issue = 1'b0;
    end
    w_last_issue = w_issue & (r_remaining == LEN_WIDTH'(1));
  end

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_len_zero) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_RUN;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last_issue) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DRAIN: begin
        // Leave only once every issued beat has been handed downstream
        if (w_fifo_empty && !r_inflight) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered command handshake and busy flag, derived from the next state
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // Address and beat counters: load on accept, advance on every issued read
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_addr      <= {ADDRWIDTHB{1'b0}};
      r_remaining <= {LEN_WIDTH{1'b0}};
    end else if (w_accept) begin
      r_addr      <= cmd_base;
      r_remaining <= cmd_len;
    end else if (w_issue) begin
      r_addr      <= r_addr + ADDRWIDTHB'(1);
      r_remaining <= r_remaining - LEN_WIDTH'(1);
    end
  end

  // RAM latency tracker: marks that ram_data carries a beat next cycle
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_last_issue;
    end
  end

  // FIFO storage: capture returning RAM data with its last flag
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_fifo_data[0] <= {WIDTHB{1'b0}};
      r_fifo_data[1] <= {WIDTHB{1'b0}};
      r_fifo_last[0] <= 1'b0;
      r_fifo_last[1] <= 1'b0;
      r_wr_ptr       <= 1'b0;
    end else if (w_push) begin
      r_fifo_data[r_wr_ptr] <= ram_data;
      r_fifo_last[r_wr_ptr] <= r_inflight_last;
      r_wr_ptr              <= ~r_wr_ptr;
    end
  end

  // FIFO read pointer and occupancy; push+pop together keeps the count
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_rd_ptr     <= 1'b0;
      r_fifo_count <= 2'd0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + 2'd1;
        2'b01:   r_fifo_count <= r_fifo_count - 2'd1;
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  // Output mapping: stream comes straight from the FIFO head registers,
  // so tdata/tlast cannot change until the head is popped
  assign cmd_ready     = r_cmd_ready;
  assign busy          = r_busy;
  assign ram_en        = w_issue;
  assign ram_addr      = r_addr;
  assign m_axis_tvalid = ~w_fifo_empty;
  assign m_axis_tdata  = r_fifo_data[r_rd_ptr];
  assign m_axis_tlast  = (~w_fifo_empty) & r_fifo_last[r_rd_ptr];

endmodule

// File: tb/tb_asym_ram_stream_reader.sv
// Directed testbench for asym_ram_stream_reader.
// RAM model: registered read, RAM[i] = i[3:0].
module tb_asym_ram_stream_reader;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_base;
  logic [10:0] cmd_len;
  logic        ram_en;
  logic [9:0]  ram_addr;
  logic [3:0]  ram_data;
  logic [3:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;

  int n_checks;
  int n_errors;

  // Stream model state
  logic mon_en;
  logic mon_pop;
  int   exp_base;
  int   exp_len;
  int   pop_idx;
  int   addr_idx;
  int   outstanding;
  int   cyc;
  int   first_valid;

  asym_ram_stream_reader dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_base      (cmd_base),
    .cmd_len       (cmd_len),
    .ram_en        (ram_en),
    .ram_addr      (ram_addr),
    .ram_data      (ram_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Registered-output RAM, contents = low nibble of the address
  always @(posedge ap_clk) begin
    if (ram_en) ram_data <= ram_addr[3:0];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Stream monitor: checks every read address, every valid beat and the issue credit rule
  always @(negedge ap_clk) begin
    if (mon_en) begin
      mon_pop = m_axis_tvalid && m_axis_tready;
      if (ram_en) begin
        check_eq("issue_rule", ((outstanding < 2) || (outstanding == 2 && mon_pop)) ? 1 : 0, 1);
        if (addr_idx < exp_len) check_eq("ram_addr", ram_addr, (exp_base + addr_idx) % 1024);
        else check_eq("extra_issue", ram_en, 0);
        addr_idx++;
      end
      if (m_axis_tvalid) begin
        if (pop_idx < exp_len) begin
          check_eq("tdata", m_axis_tdata, (exp_base + pop_idx) & 15);
          check_eq("tlast", m_axis_tlast, (pop_idx == exp_len - 1) ? 1 : 0);
        end else begin
          check_eq("extra_beat", m_axis_tvalid, 0);
        end
      end
      if (mon_pop) pop_idx++;
      outstanding = outstanding + (ram_en ? 1 : 0) - (mon_pop ? 1 : 0);
    end
  end

  task automatic arm_model(input int base, input int len);
    exp_base    = base;
    exp_len     = len;
    pop_idx     = 0;
    addr_idx    = 0;
    outstanding = 0;
    mon_en      = 1'b1;
  endtask

  function automatic logic ready_pat(input int c);
    int k;
    k = c % 6;
    return (k == 0) || (k == 3) || (k == 4);
  endfunction

  // Issue one command (called #1 after a rising edge) and follow it to IDLE
  task automatic run_cmd(input int base, input int len, input int mode);
    arm_model(base, len);
    check_eq("ready_before_cmd", cmd_ready, 1);
    cmd_base  = 10'(base);
    cmd_len   = 11'(len);
    cmd_valid = 1'b1;
    @(posedge ap_clk); #1;
    cmd_valid = 1'b0;
    check_eq("busy_after_accept", busy, 1);
    check_eq("ready_low_when_busy", cmd_ready, 0);
    cyc = 0;
    first_valid = -1;
    m_axis_tready = (mode == 0) ? 1'b1 : ready_pat(0);
    while (pop_idx < len && cyc < len * 4 + 20) begin
      @(posedge ap_clk); #1;
      cyc++;
      if (m_axis_tvalid && first_valid < 0) first_valid = cyc;
      m_axis_tready = (mode == 0) ? 1'b1 : ready_pat(cyc);
    end
    check_eq("beats_popped", pop_idx, len);
    check_eq("reads_issued", addr_idx, len);
    check_eq("first_valid_latency", first_valid, 2);
    if (mode == 0) check_eq("throughput_cycles", cyc, len + 2);
    check_eq("busy_in_drain", busy, 1);
    @(posedge ap_clk); #1;
    check_eq("busy_cleared", busy, 0);
    check_eq("ready_restored", cmd_ready, 1);
    m_axis_tready = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    mon_en = 1'b0;
    exp_base = 0; exp_len = 0; pop_idx = 0; addr_idx = 0; outstanding = 0;
    ap_rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_base = 10'd0;
    cmd_len = 11'd0;
    m_axis_tready = 1'b1;
    ram_data = 4'd0;

    // Reset state
    repeat (2) @(posedge ap_clk);
    #1;
    check_eq("rst_cmd_ready", cmd_ready, 0);
    check_eq("rst_ram_en", ram_en, 0);
    check_eq("rst_ram_addr", ram_addr, 0);
    check_eq("rst_tvalid", m_axis_tvalid, 0);
    check_eq("rst_tlast", m_axis_tlast, 0);
    check_eq("rst_tdata", m_axis_tdata, 0);
    check_eq("rst_busy", busy, 0);
    #2 ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    check_eq("ready_after_release", cmd_ready, 1);

    // Basic 4-beat command
    run_cmd(5, 4, 0);
    // Address wrap inside a command
    run_cmd(1022, 4, 0);
    // Backpressure with tready toggling 1,0,0,1,1,0
    run_cmd(10, 8, 1);

    // Zero-length command: one busy cycle, no beats
    arm_model(50, 0);
    cmd_base = 10'd50; cmd_len = 11'd0; cmd_valid = 1'b1;
    @(posedge ap_clk); #1;
    cmd_valid = 1'b0;
    check_eq("len0_busy", busy, 1);
    check_eq("len0_ready_low", cmd_ready, 0);
    @(posedge ap_clk); #1;
    check_eq("len0_busy_cleared", busy, 0);
    check_eq("len0_ready", cmd_ready, 1);
    repeat (4) @(posedge ap_clk);
    #1;
    check_eq("len0_no_tvalid", m_axis_tvalid, 0);
    check_eq("len0_no_beats", pop_idx, 0);
    check_eq("len0_no_reads", addr_idx, 0);

    // Reset in the middle of a 10-beat command
    arm_model(100, 10);
    cmd_base = 10'd100; cmd_len = 11'd10; cmd_valid = 1'b1;
    @(posedge ap_clk); #1;
    cmd_valid = 1'b0;
    cyc = 0;
    while (pop_idx < 3 && cyc < 40) begin
      @(posedge ap_clk); #1;
      cyc++;
    end
    check_eq("abort_progress", pop_idx, 3);
    mon_en = 1'b0;
    #1 ap_rst_n = 1'b0;
    #1;
    check_eq("abort_tvalid", m_axis_tvalid, 0);
    check_eq("abort_ram_en", ram_en, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_cmd_ready", cmd_ready, 0);
    check_eq("abort_tlast", m_axis_tlast, 0);
    check_eq("abort_tdata", m_axis_tdata, 0);
    check_eq("abort_ram_addr", ram_addr, 0);
    repeat (2) @(posedge ap_clk);
    #2 ap_rst_n = 1'b1;
    arm_model(0, 0);
    repeat (6) @(posedge ap_clk);
    #1;
    check_eq("post_abort_quiet", m_axis_tvalid, 0);
    check_eq("post_abort_no_beats", pop_idx + addr_idx, 0);
    run_cmd(0, 2, 0);

    // Maximum-length command at full rate, wraps once
    run_cmd(0, 2047, 0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
